pwm_capture: RTL and testbench

- Measuring receiver for the programmable PWM generator: samples one PWM waveform, e.g. a looped-back generator output pin.
- Reports the period and high time of each complete cycle in clock cycles.
- Used on-chip for self-check of the generator and by the bench as a scoreboard reference.
- Single clock domain. The PWM input is treated as asynchronous and synchronized internally.

---
 rtl/pwm_capture.sv | 155 +++++++++++++++
 tb/tb_pwm_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures rise-to-rise period and rise-to-fall high time of an
// asynchronous PWM input, in clock cycles, with a sticky overflow flag for
// stuck inputs or periods too long to count.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             level_o
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   sp;
  logic                   rise;
  logic                   fall;

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       per_cnt;
  logic [CNT_W-1:0]       per_n;
  logic [CNT_W-1:0]       hi_cnt;
  logic [CNT_W-1:0]       hi_n;
  logic [CNT_W-1:0]       period_n;
  logic [CNT_W-1:0]       high_n;
  logic                   valid_n;
  logic                   overflow_n;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~sp;
  assign fall    = ~s & sp;
  assign level_o = s;

  // Synchronizer chain plus one extra delayed copy for edge detection; runs through clear and ena=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sp     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      sp     <= s;
    end
  end

  // State, counters and result registers all load from the next-state logic below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period_o   <= '0;
      high_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_n;
      per_cnt    <= per_n;
      hi_cnt     <= hi_n;
      period_o   <= period_n;
      high_o     <= high_n;
      valid_o    <= valid_n;
      overflow_o <= overflow_n;
    end
  end

  // Next-state: clear beats ena=0 beats measuring; a full period counter with no rise means the input is stuck or too slow.
  always_comb begin
    state_n    = state;
    per_n      = per_cnt;
    hi_n       = hi_cnt;
    period_n   = period_o;
    high_n     = high_o;
    valid_n    = 1'b0;
    overflow_n = overflow_o;

    if (clear) begin
      state_n    = IDLE;
      per_n      = '0;
      hi_n       = '0;
      period_n   = '0;
      high_n     = '0;
      overflow_n = 1'b0;
    end else if (!ena) begin
      state_n = IDLE;
      per_n   = '0;
      hi_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          per_n = '0;
          hi_n  = '0;
          if (rise) begin
            state_n = HIGH;
            per_n   = CNT_ONE;
            hi_n    = CNT_ONE;
          end
        end
        HIGH: begin
          if (per_cnt == CNT_MAX && !rise) begin
            state_n    = IDLE;
            per_n      = '0;
            hi_n       = '0;
            overflow_n = 1'b1;
          end else if (fall) begin
            state_n = LOW;
            per_n   = per_cnt + CNT_ONE;
          end else begin
            per_n = per_cnt + CNT_ONE;
            hi_n  = hi_cnt + CNT_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            period_n = per_cnt;
            high_n   = hi_cnt;
            valid_n  = 1'b1;
            state_n  = HIGH;
            per_n    = CNT_ONE;
            hi_n     = CNT_ONE;
          end else if (per_cnt == CNT_MAX) begin
            state_n    = IDLE;
            per_n      = '0;
            hi_n       = '0;
            overflow_n = 1'b1;
          end else begin
            per_n = per_cnt + CNT_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          per_n   = '0;
          hi_n    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM waveforms into pwm_capture (8-bit counters) and
// compares every valid_o result against a queue of expected measurements.
module tb_pwm_capture;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;

  typedef struct {
    int high_len;
    int low_len;
    int reps;
    bit new_group;
    int exp_period;
    int exp_high;
  } vec_t;

  typedef struct {
    int period;
    int high;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             clear;
  logic             pwm_in;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             overflow_o;
  logic             level_o;

  int   vectors;
  int   miscompares;
  int   cyc;
  int   first_valid_cyc;
  int   second_rise_cyc;
  bit   prev_valid;
  exp_t prev_exp;
  exp_t sbq[$];
  vec_t vecs[6];

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .clear     (clear),
    .pwm_in    (pwm_in),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .overflow_o(overflow_o),
    .level_o   (level_o)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle index used to measure latency
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One PWM period starting with a rise; that rise completes the previous period.
  task automatic applyStimulus(input int h, input int l, input int ep, input int eh);
    if (prev_valid) begin
      sbq.push_back(prev_exp);
      if (second_rise_cyc < 0) second_rise_cyc = cyc;
    end
    prev_exp.period = ep;
    prev_exp.high   = eh;
    prev_valid      = 1'b1;
    pwm_in = 1'b1;
    repeat (h) tick();
    pwm_in = 1'b0;
    repeat (l) tick();
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prev_valid      = 1'b0;
    first_valid_cyc = -1;
    second_rise_cyc = -1;
    @(negedge clk);
    checkOutput("clear_period", int'(period_o), 0);
    checkOutput("clear_high", int'(high_o), 0);
    checkOutput("clear_overflow", int'(overflow_o), 0);
    tick();
  endtask

  // Scoreboard: every valid_o pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL spurious_valid: got valid_o=1 with period %0d high %0d, expected none", period_o, high_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("period_o", int'(period_o), e.period);
        checkOutput("high_o", int'(high_o), e.high);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
    end
  end

  // Global time bound
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vectors         = 0;
    miscompares     = 0;
    prev_valid      = 1'b0;
    first_valid_cyc = -1;
    second_rise_cyc = -1;
    vecs[0] = '{high_len: 3, low_len: 5,  reps: 4, new_group: 1'b1, exp_period: 8,  exp_high: 3};
    vecs[1] = '{high_len: 1, low_len: 1,  reps: 8, new_group: 1'b1, exp_period: 2,  exp_high: 1};
    vecs[2] = '{high_len: 2, low_len: 6,  reps: 3, new_group: 1'b1, exp_period: 8,  exp_high: 2};
    vecs[3] = '{high_len: 6, low_len: 2,  reps: 3, new_group: 1'b0, exp_period: 8,  exp_high: 6};
    vecs[4] = '{high_len: 4, low_len: 4,  reps: 3, new_group: 1'b1, exp_period: 8,  exp_high: 4};
    vecs[5] = '{high_len: 5, low_len: 11, reps: 3, new_group: 1'b1, exp_period: 16, exp_high: 5};

    rst    = 1'b1;
    ena    = 1'b1;
    clear  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) tick();
    checkOutput("reset_period", int'(period_o), 0);
    checkOutput("reset_high", int'(high_o), 0);
    checkOutput("reset_valid", int'(valid_o), 0);
    checkOutput("reset_overflow", int'(overflow_o), 0);
    checkOutput("reset_level", int'(level_o), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Table-driven waveforms
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].new_group) begin
        pwm_in = 1'b0;
        repeat (10) tick();
        pulseClear();
      end
      for (int r = 0; r < vecs[i].reps; r++)
        applyStimulus(vecs[i].high_len, vecs[i].low_len, vecs[i].exp_period, vecs[i].exp_high);
      if (i == 0)
        checkOutput("first_valid_latency", first_valid_cyc - second_rise_cyc, SYNC_STAGES + 1);
    end
    repeat (10) tick();

    // Stuck-high input: overflow 255 cycles after entering HIGH, results hold
    pulseClear();
    applyStimulus(3, 5, 8, 3);
    applyStimulus(3, 5, 8, 3);
    sbq.push_back(prev_exp);
    prev_valid = 1'b0;
    pwm_in = 1'b1;
    repeat (257) @(posedge clk);
    @(negedge clk);
    checkOutput("overflow_before", int'(overflow_o), 0);
    @(negedge clk);
    checkOutput("overflow_at_255", int'(overflow_o), 1);
    checkOutput("overflow_period_hold", int'(period_o), 8);
    checkOutput("overflow_high_hold", int'(high_o), 3);
    tick();
    pwm_in = 1'b0;
    repeat (4) tick();
    for (int r = 0; r < 3; r++) applyStimulus(4, 4, 8, 4);
    repeat (4) tick();
    checkOutput("overflow_sticky", int'(overflow_o), 1);
    checkOutput("resume_period", int'(period_o), 8);
    checkOutput("resume_high", int'(high_o), 4);
    pulseClear();

    // ena=0 for 20 cycles mid-stream: no valid, results hold, two rises needed after
    for (int r = 0; r < 3; r++) applyStimulus(3, 5, 8, 3);
    ena = 1'b0;
    prev_valid = 1'b0;
    applyStimulus(3, 5, 8, 3);
    prev_valid = 1'b0;
    applyStimulus(3, 5, 8, 3);
    prev_valid = 1'b0;
    repeat (4) tick();
    checkOutput("ena_period_hold", int'(period_o), 8);
    checkOutput("ena_high_hold", int'(high_o), 3);
    ena = 1'b1;
    repeat (4) tick();
    for (int r = 0; r < 3; r++) applyStimulus(2, 6, 8, 2);
    repeat (6) tick();

    // Asynchronous reset in the middle of a high phase
    pulseClear();
    applyStimulus(3, 5, 8, 3);
    applyStimulus(3, 5, 8, 3);
    sbq.push_back(prev_exp);
    prev_valid = 1'b0;
    pwm_in = 1'b1;
    repeat (5) tick();
    checkOutput("pre_reset_level", int'(level_o), 1);
    checkOutput("pre_reset_period", int'(period_o), 8);
    checkOutput("pre_reset_queue", sbq.size(), 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_period", int'(period_o), 0);
    checkOutput("async_rst_high", int'(high_o), 0);
    checkOutput("async_rst_valid", int'(valid_o), 0);
    checkOutput("async_rst_overflow", int'(overflow_o), 0);
    checkOutput("async_rst_level", int'(level_o), 0);
    pwm_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    first_valid_cyc = -1;
    second_rise_cyc = -1;
    repeat (3) tick();
    for (int r = 0; r < 3; r++) applyStimulus(3, 5, 8, 3);
    checkOutput("post_reset_latency", first_valid_cyc - second_rise_cyc, SYNC_STAGES + 1);
    repeat (10) tick();

    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
